// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: timer register map, control/status
// bit positions, timer FSM encoding and the value returned for unmapped reads.
package mem_responder_pkg;

   localparam logic [2:0] OFF_RLO  = 3'd0;
   localparam logic [2:0] OFF_RHI  = 3'd1;
   localparam logic [2:0] OFF_CTRL = 3'd2;
   localparam logic [2:0] OFF_STAT = 3'd3;
   localparam logic [2:0] OFF_CLO  = 3'd4;
   localparam logic [2:0] OFF_CHI  = 3'd5;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_IE      = 1;
   localparam int CTRL_ONESHOT = 2;
   localparam int STAT_EXP     = 0;

   typedef enum logic {
      TMR_IDLE = 1'b0,
      TMR_RUN  = 1'b1
   } tmr_state_e;

   localparam logic [7:0] UNMAPPED_RD = 8'hFF;
   localparam logic [7:0] RESERVED_RD = 8'h00;

endpackage

// File: rtl/mem_responder_if.sv
// Processor-side bus bundle plus the timer interrupt and a debug view of the timer FSM.
interface mem_responder_if;
   import mem_responder_pkg::*;

   // No handshake: every rising clk edge is one access, address/wr_data/wr_enable are
   // sampled on that edge and the access always completes there (no valid/ready, no wait).
   logic [15:0] address;
   logic [7:0]  wr_data;
   logic        wr_enable;
   logic        irqn;
   tmr_state_e  tmr_state;

   modport master (output address, wr_data, wr_enable, input irqn, tmr_state);
   modport slave  (input address, wr_data, wr_enable, output irqn, tmr_state);

endinterface

// File: rtl/resp_timer.sv
// 16-bit down-counting timer with reload, one-shot mode, sticky expiry flag,
// registered active-low interrupt and a high-byte snapshot for tear-free count reads.
module resp_timer
   import mem_responder_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   mem_responder_if.slave  bus,
   input  logic            sel,
   output logic [7:0]      rdata
);

   logic [7:0]  rlo_q, rlo_d, rhi_q, rhi_d, shadow_q, shadow_d;
   logic        en_q, en_d, ie_q, ie_d, oneshot_q, oneshot_d;
   logic        exp_q, exp_d, irqn_q, irqn_d;
   logic [15:0] count_q, count_d;
   tmr_state_e  state_q, state_d;

   logic [2:0]  off;
   logic        wr, rd, ctrl_wr, exp_set, exp_clr;
   logic [15:0] reload;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rlo_q     <= 8'h00;
         rhi_q     <= 8'h00;
         en_q      <= 1'b0;
         ie_q      <= 1'b0;
         oneshot_q <= 1'b0;
         exp_q     <= 1'b0;
         count_q   <= 16'h0000;
         shadow_q  <= 8'h00;
         state_q   <= TMR_IDLE;
         irqn_q    <= 1'b1;
      end else begin
         rlo_q     <= rlo_d;
         rhi_q     <= rhi_d;
         en_q      <= en_d;
         ie_q      <= ie_d;
         oneshot_q <= oneshot_d;
         exp_q     <= exp_d;
         count_q   <= count_d;
         shadow_q  <= shadow_d;
         state_q   <= state_d;
         irqn_q    <= irqn_d;
      end
   end

   always_comb begin
      off       = bus.address[2:0];
      wr        = sel & bus.wr_enable;
      rd        = sel & ~bus.wr_enable;
      ctrl_wr   = wr && (off == OFF_CTRL);
      reload    = {rhi_q, rlo_q};
      rlo_d     = rlo_q;
      rhi_d     = rhi_q;
      en_d      = en_q;
      ie_d      = ie_q;
      oneshot_d = oneshot_q;
      count_d   = count_q;
      shadow_d  = shadow_q;
      state_d   = state_q;
      exp_set   = 1'b0;
      exp_clr   = 1'b0;

      // Read data always reflects the state before this edge's update.
      case (off)
         OFF_RLO:  rdata = rlo_q;
         OFF_RHI:  rdata = rhi_q;
         OFF_CTRL: rdata = {5'b0, oneshot_q, ie_q, en_q};
         OFF_STAT: rdata = {7'b0, exp_q};
         OFF_CLO:  rdata = count_q[7:0];
         OFF_CHI:  rdata = shadow_q;
         default:  rdata = RESERVED_RD;
      endcase

      if (wr) begin
         case (off)
            OFF_RLO: rlo_d = bus.wr_data;
            OFF_RHI: rhi_d = bus.wr_data;
            OFF_CTRL: begin
               en_d      = bus.wr_data[CTRL_EN];
               ie_d      = bus.wr_data[CTRL_IE];
               oneshot_d = bus.wr_data[CTRL_ONESHOT];
               if (bus.wr_data[CTRL_EN]) begin
                  count_d = reload;
                  state_d = TMR_RUN;
               end else begin
                  state_d = TMR_IDLE;
               end
            end
            OFF_STAT: exp_clr = bus.wr_data[STAT_EXP];
            default: ;
         endcase
      end

      if (rd && (off == OFF_STAT)) exp_clr = 1'b1;
      if (rd && (off == OFF_CLO))  shadow_d = count_q[15:8];

      // A CTRL write owns count/state on its edge; otherwise the counter runs.
      if ((state_q == TMR_RUN) && !ctrl_wr) begin
         if (count_q != 16'h0000) begin
            count_d = count_q - 16'd1;
         end else begin
            exp_set = 1'b1;
            if (oneshot_q) begin
               en_d    = 1'b0;
               state_d = TMR_IDLE;
            end else begin
               count_d = reload;
            end
         end
      end

      exp_d  = exp_set ? 1'b1 : (exp_clr ? 1'b0 : exp_q);
      irqn_d = ~(exp_q & ie_q);
   end

   assign bus.irqn      = irqn_q;
   assign bus.tmr_state = state_q;

endmodule

// File: rtl/mem_responder.sv
// Single-cycle memory responder: internal RAM, a timer register window and a
// registered read-data mux; unmapped reads return all-ones.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int          RAM_AW   = 11,
   parameter logic [15:0] TMR_BASE = 16'hD000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [15:0] address,
   input  logic [7:0]  wr_data,
   input  logic        wr_enable,
   output logic [7:0]  rd_data,
   output logic        irqn
);

   localparam int RAM_WORDS = 1 << RAM_AW;

   mem_responder_if bus_i ();

   logic [7:0] ram_q [RAM_WORDS];
   logic [7:0] rd_data_q, rd_data_d;
   logic [7:0] tmr_rdata;
   logic       ram_sel, tmr_sel;

   assign bus_i.address   = address;
   assign bus_i.wr_data   = wr_data;
   assign bus_i.wr_enable = wr_enable;

   always_comb begin
      ram_sel = (bus_i.address >> RAM_AW) == 16'd0;
      tmr_sel = bus_i.address[15:3] == TMR_BASE[15:3];
   end

   resp_timer u_timer (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_i.slave),
      .sel    (tmr_sel),
      .rdata  (tmr_rdata)
   );

   // RAM contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (ram_sel && bus_i.wr_enable) ram_q[bus_i.address[RAM_AW-1:0]] <= bus_i.wr_data;
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (!bus_i.wr_enable) begin
         if (ram_sel)      rd_data_d = ram_q[bus_i.address[RAM_AW-1:0]];
         else if (tmr_sel) rd_data_d = tmr_rdata;
         else              rd_data_d = UNMAPPED_RD;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rd_data_q <= 8'h00;
      else         rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;
   assign irqn    = bus_i.irqn;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter RAM_AW, default 11, meaning RAM address width, giving 2 KB at 0x0000-0x07FF.
REQ-002 The block SHALL have parameter TMR_BASE, default 16'hD000, meaning the base address of the 8-byte timer window.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port address, input, 16 bits: the processor bus address.
REQ-006 The block SHALL have port wr_data, input, 8 bits: the processor write data.
REQ-007 The block SHALL have port wr_enable, input, 1 bit: 1 = write cycle, 0 = read cycle.
REQ-008 The block SHALL have port rd_data, output, 8 bits: registered read data.
REQ-009 The block SHALL have port irqn, output, 1 bit: active-low timer interrupt request.

Function
REQ-010 Bus access: every clk edge is one access; the block samples address, wr_data and wr_enable; there is no handshake or wait state.
REQ-011 Read latency: rd_data SHALL present the data for the address sampled at edge N after edge N and hold it until edge N+1; write cycles leave rd_data unchanged.
REQ-012 RAM: addresses below 2**RAM_AW SHALL map to internal RAM; a write updates the byte at edge N; a read of that address at edge N+1 returns the new value.
REQ-013 Unmapped reads SHALL return 8'hFF; unmapped writes SHALL be ignored.
REQ-014 Timer map (offset from TMR_BASE):
- 0 RLO: reload low, read/write.
- 1 RHI: reload high, read/write.
- 2 CTRL: bit0 EN, bit1 IE, bit2 ONESHOT, read/write, other bits read 0.
- 3 STAT: bit0 EXP; reading returns EXP and then clears it; writing 1 to bit0 clears it.
- 4 CLO: count low, read-only; the read latches count[15:8] into a shadow register.
- 5 CHI: returns the shadow register.
- 6-7: reserved, read 8'h00.
REQ-015 Timer states SHALL be IDLE and RUN. A CTRL write with EN=1 loads count = {RHI,RLO} and enters RUN; a CTRL write with EN=0 enters IDLE and holds count.
REQ-016 In RUN, count SHALL decrement by 1 per clk while nonzero; at count==0 it SHALL set EXP and then either:
- continuous: reload {RHI,RLO} on the same edge, giving period = reload+1 cycles; or
- ONESHOT=1: clear EN and go to IDLE.
REQ-017 Reload 0 in continuous mode SHALL set EXP on every cycle.
REQ-018 RLO/RHI writes during RUN SHALL NOT alter the current count; the new value takes effect at the next reload.
REQ-019 If EXP set and EXP clear (STAT read or write) occur on the same edge, set SHALL win.
REQ-020 irqn SHALL equal ~(EXP & IE), registered, with no combinational path from the bus.
REQ-021 Reads of CTRL/STAT SHALL reflect state before the edge's update.

Reset
REQ-022 resetn low SHALL asynchronously force: rd_data=8'h00, irqn=1, RLO=RHI=8'h00, CTRL=8'h00, EXP=0, count=16'h0000, shadow=8'h00, state=IDLE.
REQ-023 RAM contents SHALL NOT be reset; they are undefined after power-up.
REQ-024 Reset asserted mid-count SHALL abandon the count; after release the timer stays IDLE until a CTRL write.

Structure
REQ-025 Package mem_responder_pkg SHALL hold the register offsets (RLO..CHI), the CTRL/STAT bit indices, the IDLE/RUN state encoding and the unmapped read value.
REQ-026 The timer (count, reload, FSM, EXP, shadow) SHALL be the sub-module resp_timer; address decode, RAM and the rd_data mux stay in mem_responder.

Verification
REQ-027 RAM: write 8'hA5 to 0x0123, then read 0x0123 -> rd_data=8'hA5 one cycle after the read edge; read 0x4000 -> 8'hFF.
REQ-028 Continuous timer: RLO=3, RHI=0, CTRL=8'h03 -> EXP sets every 4 cycles and irqn falls 1 cycle after EXP; STAT read -> 8'h01, then irqn=1.
REQ-029 One-shot: RLO=2, CTRL=8'h05 -> exactly one EXP, after which CTRL reads 8'h04 (EN=0) and count holds 0.
REQ-030 Snapshot: running with count near 16'h0100, read CLO then CHI -> the {CHI,CLO} pair is consistent (no low-byte wrap mismatch).
REQ-031 Collision: issue a STAT write 8'h01 on the same edge that count hits 0 -> EXP stays 1.
REQ-032 Mid-run reset: pulse resetn low for 1 cycle mid-count -> all registers reset, irqn=1, no EXP until CTRL is rewritten.
